// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply (radix-4 Booth) / divide (restoring on magnitudes) unit
// producing HI/LO for the control unit. Handshake: start is taken when busy==0; done pulses once with results.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [2:0]       fsm_state
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]         state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH:0]     mb;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   dmag;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_diff;
   logic               ge;
   logic               neg_q;
   logic               neg_r;
   logic               dbz;

   // Magnitudes as unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
   assign a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
   assign b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;

   always_comb begin
      addend = '0;
      case (mb[2:0])
         3'b001, 3'b010: addend = mcand;
         3'b011:         addend = mcand << 1;
         3'b100:         addend = ~(mcand << 1) + 1'b1;
         3'b101, 3'b110: addend = ~mcand + 1'b1;
         default:        addend = '0;
      endcase
      acc_next = acc + addend;
   end

   // The shifted remainder needs WIDTH+1 bits so the compare is exact when |B| = 2^(WIDTH-1).
   always_comb begin
      rem_sh   = {rem, quo[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, dmag};
      ge       = ~rem_diff[WIDTH];
      rem_next = ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= S_IDLE;
         cnt   <= '0;
         acc   <= '0;
         mcand <= '0;
         mb    <= '0;
         quo   <= '0;
         dmag  <= '0;
         rem   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dbz   <= 1'b0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  cnt   <= '0;
                  acc   <= '0;
                  mcand <= {{WIDTH{A[WIDTH-1]}}, A};
                  mb    <= {B, 1'b0};
                  quo   <= a_mag;
                  dmag  <= b_mag;
                  rem   <= '0;
                  neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
                  neg_r <= A[WIDTH-1];
                  if (!op) begin
                     state <= S_MUL;
                  end else if (B == '0) begin
                     state <= S_DONE;
                     dbz   <= 1'b1;
                  end else begin
                     state <= S_DIV;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_MUL: begin
               acc   <= acc_next;
               mcand <= mcand << 2;
               mb    <= {2'b00, mb[WIDTH:2]};
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(WIDTH/2 - 1)) begin
                  HI    <= acc_next[2*WIDTH-1:WIDTH];
                  LO    <= acc_next[WIDTH-1:0];
                  dbz   <= 1'b0;
                  state <= S_DONE;
               end
            end
            S_DIV: begin
               rem <= rem_next;
               quo <= {quo[WIDTH-2:0], ge};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= S_FIX;
               end
            end
            S_FIX: begin
               LO    <= neg_q ? (~quo + 1'b1) : quo;
               HI    <= neg_r ? (~rem + 1'b1) : rem;
               dbz   <= 1'b0;
               state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy        = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
   assign done        = (state == S_DONE);
   assign div_by_zero = dbz;
   assign fsm_state   = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written
// multi-cycle corner sequences, and randomized ops against a plain-arithmetic model.
module tb_muldiv_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic        op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [2:0]  fsm_state;

   int checks = 0;
   int errors = 0;

   logic [64:0] exp_q[$];

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t vecs[10];

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clock      (clock),
      .clear      (clear),
      .start      (start),
      .op         (op),
      .A          (A),
      .B          (B),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .HI         (HI),
      .LO         (LO),
      .fsm_state  (fsm_state)
   );

   always #5 clock = ~clock;

   initial begin
      #5000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Called just after an edge; lat counts edges from the start edge (inclusive) to the done cycle.
   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo,
                         output logic dz);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      @(posedge clock);
      #1;
      start = 1'b0;
      op    = 1'($urandom_range(0, 1));
      A     = $urandom;
      B     = $urandom;
      lat   = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clock);
         #1;
         lat++;
      end
      hi = HI;
      lo = LO;
      dz = div_by_zero;
   endtask

   function automatic logic [64:0] model(input logic o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] prev);
      longint p;
      int     q;
      int     r;
      if (!o) begin
         p = longint'($signed(a)) * longint'($signed(b));
         return {1'b0, p};
      end
      if (b == 32'd0) return {1'b1, prev};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {1'b0, r, q};
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] corners[6];
      corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};
      case ($urandom_range(0, 7))
         0:       return corners[$urandom_range(0, 5)];
         1:       return 32'($urandom_range(0, 20));
         2:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          lat;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      logic        seen;
      logic [63:0] m_prev;
      logic [64:0] e;
      logic        ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int          exp_lat;

      vecs[0] = '{1'b0, 32'd7,        32'hFFFFFFFD, 17, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 17, 32'h40000000, 32'h00000000, 1'b0};
      vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 17, 32'hFFFFFFFF, 32'h80000001, 1'b0};
      vecs[3] = '{1'b1, 32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 1'b0};
      vecs[5] = '{1'b0, 32'd3,        32'h55555556, 17, 32'h00000001, 32'h00000002, 1'b0};
      vecs[6] = '{1'b1, 32'd5,        32'd0,        1,  32'h00000001, 32'h00000002, 1'b1};
      vecs[7] = '{1'b1, 32'd100,      32'd7,        34, 32'h00000002, 32'h0000000E, 1'b0};
      vecs[8] = '{1'b1, 32'd7,        32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[9] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 17, 32'h00000000, 32'h00000001, 1'b0};

      clear = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      A     = '0;
      B     = '0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_dbz",  32'(div_by_zero), 32'd0);
      check("reset_hi",   HI, 32'd0);
      check("reset_lo",   LO, 32'd0);
      clear = 1'b0;
      @(posedge clock);
      #1;

      // Table entries are issued back to back; entry 6 relies on entry 5's HI/LO.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, hi, lo, dz);
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
         check($sformatf("vec%0d_dz", i), 32'(dz), 32'(vecs[i].dz));
      end
      @(posedge clock);
      #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_not_busy",  32'(busy), 32'd0);

      // A second start while a DIV is in flight must be ignored.
      start = 1'b1; op = 1'b1; A = 32'd1000; B = 32'hFFFFFFF7;
      @(posedge clock);
      #1;
      start = 1'b0;
      lat   = 1;
      repeat (2) begin
         @(posedge clock);
         #1;
         lat++;
      end
      start = 1'b1; op = 1'b0; A = 32'd3; B = 32'd4;
      @(posedge clock);
      #1;
      lat++;
      start = 1'b0;
      check("ign_busy", 32'(busy), 32'd1);
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clock);
         #1;
         lat++;
      end
      check("ign_lat", 32'(lat), 32'd34);
      check("ign_lo",  LO, 32'hFFFFFF91);
      check("ign_hi",  HI, 32'd1);
      @(posedge clock);
      #1;

      // clear in the middle of a DIV aborts it with no done.
      start = 1'b1; op = 1'b1; A = 32'd12345; B = 32'd67;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      clear = 1'b1;
      @(posedge clock);
      #1;
      clear = 1'b0;
      check("clr_busy", 32'(busy), 32'd0);
      check("clr_done", 32'(done), 32'd0);
      check("clr_hi",   HI, 32'd0);
      check("clr_lo",   LO, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) seen = 1'b1;
      end
      check("clr_no_done", 32'(seen), 32'd0);

      // Issue a DIV in the done cycle of a MUL.
      run_op(1'b0, 32'd3, 32'd4, lat, hi, lo, dz);
      check("b2b_mul_lat", 32'(lat), 32'd17);
      check("b2b_mul_lo",  lo, 32'd12);
      run_op(1'b1, 32'd100, 32'd7, lat, hi, lo, dz);
      check("b2b_div_lat", 32'(lat), 32'd34);
      check("b2b_div_lo",  lo, 32'd14);
      check("b2b_div_hi",  hi, 32'd2);

      m_prev = {32'd2, 32'd14};
      for (int n = 0; n < 1500; n++) begin
         ro = 1'($urandom_range(0, 1));
         ra = pick();
         rb = pick();
         e  = model(ro, ra, rb, m_prev);
         exp_q.push_back(e);
         m_prev  = e[63:0];
         exp_lat = !ro ? 17 : ((rb == 32'd0) ? 1 : 34);
         run_op(ro, ra, rb, lat, hi, lo, dz);
         e = exp_q.pop_front();
         check($sformatf("rnd%0d_lat op=%0d a=%h b=%h", n, ro, ra, rb), 32'(lat), 32'(exp_lat));
         check($sformatf("rnd%0d_hi op=%0d a=%h b=%h", n, ro, ra, rb), hi, e[63:32]);
         check($sformatf("rnd%0d_lo op=%0d a=%h b=%h", n, ro, ra, rb), lo, e[31:0]);
         check($sformatf("rnd%0d_dz op=%0d a=%h b=%h", n, ro, ra, rb), 32'(dz), 32'(e[64]));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clock);
            #1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
